// File: rtl/addr_trans.sv
// Virtual-to-physical translation stage: direct-address, DMW window or TLB lookup,
// one request at a time, result returned over a valid/ready handshake.
module addr_trans (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic [1:0]  req_type,
  input  logic        csr_da,
  input  logic        csr_pg,
  input  logic [1:0]  csr_plv,
  input  logic [9:0]  csr_asid,
  input  logic [31:0] csr_dmw0,
  input  logic [31:0] csr_dmw1,
  input  logic [1:0]  da_mat,
  output logic        tlb_fetch,
  output logic [18:0] tlb_vppn,
  output logic        tlb_odd_page,
  output logic [9:0]  tlb_asid,
  input  logic        tlb_found,
  input  logic [5:0]  tlb_ps,
  input  logic [19:0] tlb_ppn,
  input  logic        tlb_v,
  input  logic        tlb_d,
  input  logic [1:0]  tlb_mat,
  input  logic [1:0]  tlb_plv,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_paddr,
  output logic [1:0]  resp_mat,
  output logic [31:0] resp_vaddr,
  output logic        resp_ex,
  output logic [5:0]  resp_ecode
);

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  localparam logic [1:0] TypeFetch = 2'd0;
  localparam logic [1:0] TypeLoad  = 2'd1;
  localparam logic [1:0] TypeStore = 2'd2;

  localparam logic [5:0] EcTlbr = 6'h3f;
  localparam logic [5:0] EcPif  = 6'h03;
  localparam logic [5:0] EcPil  = 6'h01;
  localparam logic [5:0] EcPis  = 6'h02;
  localparam logic [5:0] EcPpi  = 6'h07;
  localparam logic [5:0] EcPme  = 6'h04;

  state_e      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [1:0]  plv_q, plv_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] paddr_q, paddr_d;
  logic [1:0]  mat_q, mat_d;
  logic        ex_q, ex_d;
  logic [5:0]  ecode_q, ecode_d;

  logic       accept;
  logic       dmw0_hit, dmw1_hit;
  logic [1:0] type_norm;

  // Only PLV0 and PLV3 have enable bits in a DMW register.
  function automatic logic dmw_hit(input logic [31:0] dmw, input logic [31:0] va,
                                   input logic [1:0] plv);
    logic plv_en;
    plv_en = ((plv == 2'd0) && dmw[0]) || ((plv == 2'd3) && dmw[3]);
    return (va[31:29] == dmw[31:29]) && plv_en;
  endfunction

  assign req_ready    = (state_q == StIdle) && !flush && !reset;
  assign accept       = req_valid && req_ready;
  assign type_norm    = (req_type == 2'd3) ? TypeLoad : req_type;
  assign dmw0_hit     = dmw_hit(csr_dmw0, req_vaddr, csr_plv);
  assign dmw1_hit     = dmw_hit(csr_dmw1, req_vaddr, csr_plv);

  assign tlb_vppn     = req_vaddr[31:13];
  assign tlb_odd_page = req_vaddr[12];
  assign tlb_asid     = csr_asid;

  assign resp_valid   = (state_q == StResp);
  assign resp_paddr   = paddr_q;
  assign resp_mat     = mat_q;
  assign resp_vaddr   = vaddr_q;
  assign resp_ex      = ex_q;
  assign resp_ecode   = ecode_q;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    plv_d     = plv_q;
    vaddr_d   = vaddr_q;
    paddr_d   = paddr_q;
    mat_d     = mat_q;
    ex_d      = ex_q;
    ecode_d   = ecode_q;
    tlb_fetch = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          vaddr_d = req_vaddr;
          type_d  = type_norm;
          plv_d   = csr_plv;
          ex_d    = 1'b0;
          ecode_d = 6'h00;
          // DA wins over PG, so csr_pg never needs to be consulted here.
          if (csr_da) begin
            paddr_d = req_vaddr;
            mat_d   = da_mat;
            state_d = StResp;
          end else if (dmw0_hit) begin
            paddr_d = {csr_dmw0[27:25], req_vaddr[28:0]};
            mat_d   = csr_dmw0[5:4];
            state_d = StResp;
          end else if (dmw1_hit) begin
            paddr_d = {csr_dmw1[27:25], req_vaddr[28:0]};
            mat_d   = csr_dmw1[5:4];
            state_d = StResp;
          end else begin
            tlb_fetch = 1'b1;
            state_d   = StLookup;
          end
        end
      end
      StLookup: begin
        ex_d    = 1'b1;
        paddr_d = 32'h0;
        mat_d   = 2'd0;
        if (!tlb_found) begin
          ecode_d = EcTlbr;
        end else if (!tlb_v) begin
          ecode_d = (type_q == TypeFetch) ? EcPif :
                    (type_q == TypeStore) ? EcPis : EcPil;
        end else if (plv_q > tlb_plv) begin
          ecode_d = EcPpi;
        end else if ((type_q == TypeStore) && !tlb_d) begin
          ecode_d = EcPme;
        end else begin
          ex_d    = 1'b0;
          ecode_d = 6'h00;
          mat_d   = tlb_mat;
          paddr_d = (tlb_ps == 6'd12) ? {tlb_ppn, vaddr_q[11:0]}
                                      : {tlb_ppn[19:9], vaddr_q[20:0]};
        end
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      type_q  <= 2'd0;
      plv_q   <= 2'd0;
      vaddr_q <= 32'h0;
      paddr_q <= 32'h0;
      mat_q   <= 2'd0;
      ex_q    <= 1'b0;
      ecode_q <= 6'h00;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      plv_q   <= plv_d;
      vaddr_q <= vaddr_d;
      paddr_q <= paddr_d;
      mat_q   <= mat_d;
      ex_q    <= ex_d;
      ecode_q <= ecode_d;
    end
  end

  logic unused_pg;
  assign unused_pg = csr_pg;

endmodule

// File: tb/tb_addr_trans.sv
// Directed self-checking bench for addr_trans: DA, DMW, TLB hit/exception paths,
// response back-pressure and flush behaviour.
module tb_addr_trans;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_type;
  logic        csr_da, csr_pg;
  logic [1:0]  csr_plv;
  logic [9:0]  csr_asid;
  logic [31:0] csr_dmw0, csr_dmw1;
  logic [1:0]  da_mat;
  logic        tlb_fetch;
  logic [18:0] tlb_vppn;
  logic        tlb_odd_page;
  logic [9:0]  tlb_asid;
  logic        tlb_found;
  logic [5:0]  tlb_ps;
  logic [19:0] tlb_ppn;
  logic        tlb_v, tlb_d;
  logic [1:0]  tlb_mat, tlb_plv;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_paddr;
  logic [1:0]  resp_mat;
  logic [31:0] resp_vaddr;
  logic        resp_ex;
  logic [5:0]  resp_ecode;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  addr_trans dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_type(req_type),
    .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv), .csr_asid(csr_asid),
    .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1), .da_mat(da_mat),
    .tlb_fetch(tlb_fetch), .tlb_vppn(tlb_vppn), .tlb_odd_page(tlb_odd_page),
    .tlb_asid(tlb_asid), .tlb_found(tlb_found), .tlb_ps(tlb_ps), .tlb_ppn(tlb_ppn),
    .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_mat(tlb_mat), .tlb_plv(tlb_plv),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_mat(resp_mat), .resp_vaddr(resp_vaddr), .resp_ex(resp_ex),
    .resp_ecode(resp_ecode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one cycle; caller has already set CSRs.
  task automatic present(input logic [31:0] va, input logic [1:0] typ);
    req_valid = 1'b1;
    req_vaddr = va;
    req_type  = typ;
    #1;
  endtask

  task automatic complete();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("idle_after_complete", 32'(resp_valid), 0);
    check("ready_after_complete", 32'(req_ready), 1);
  endtask

  task automatic set_tlb(input logic found, input logic [5:0] ps, input logic [19:0] ppn,
                         input logic v, input logic d, input logic [1:0] mat,
                         input logic [1:0] plv);
    tlb_found = found; tlb_ps = ps; tlb_ppn = ppn;
    tlb_v = v; tlb_d = d; tlb_mat = mat; tlb_plv = plv;
  endtask

  // TLB-path request: fetch in accept cycle, result two edges later.
  task automatic run_tlb(input string tag, input logic [31:0] va, input logic [1:0] typ,
                         input logic [31:0] exp_paddr, input logic exp_ex,
                         input logic [5:0] exp_ecode);
    present(va, typ);
    check({tag, "_fetch"}, 32'(tlb_fetch), 1);
    tick();
    req_valid = 1'b0;
    check({tag, "_lookup_novalid"}, 32'(resp_valid), 0);
    check({tag, "_lookup_nofetch"}, 32'(tlb_fetch), 0);
    tick();
    check({tag, "_valid"}, 32'(resp_valid), 1);
    check({tag, "_paddr"}, resp_paddr, exp_paddr);
    check({tag, "_ex"}, 32'(resp_ex), 32'(exp_ex));
    check({tag, "_ecode"}, 32'(resp_ecode), 32'(exp_ecode));
    check({tag, "_vaddr"}, resp_vaddr, va);
    complete();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b1; req_vaddr = 32'h0040_0000;
    req_type = 2'd1; csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0; csr_asid = 10'h155;
    csr_dmw0 = 32'h0; csr_dmw1 = 32'h0; da_mat = 2'd0; resp_ready = 1'b0;
    set_tlb(1'b0, 6'd12, 20'h0, 1'b0, 1'b0, 2'd0, 2'd0);
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tlb_fetch", 32'(tlb_fetch), 0);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_paddr", resp_paddr, 32'h0);
    check("rst_resp_ecode", 32'(resp_ecode), 0);
    check("rst_resp_ex", 32'(resp_ex), 0);

    // Direct-address mode; PG set as well to show DA priority.
    csr_da = 1'b1; da_mat = 2'd1;
    present(32'h1C00_0000, 2'd1);
    check("da_ready", 32'(req_ready), 1);
    check("da_nofetch", 32'(tlb_fetch), 0);
    tick();
    req_valid = 1'b0;
    check("da_valid", 32'(resp_valid), 1);
    check("da_paddr", resp_paddr, 32'h1C00_0000);
    check("da_mat", 32'(resp_mat), 1);
    check("da_ex", 32'(resp_ex), 0);
    complete();

    // DMW0 hit at PLV0.
    csr_da = 1'b0; csr_dmw0 = 32'hA000_0011; csr_plv = 2'd0;
    present(32'hA000_1234, 2'd0);
    check("dmw0_nofetch", 32'(tlb_fetch), 0);
    tick();
    req_valid = 1'b0;
    check("dmw0_valid", 32'(resp_valid), 1);
    check("dmw0_paddr", resp_paddr, 32'h0000_1234);
    check("dmw0_mat", 32'(resp_mat), 1);
    complete();

    // DMW1 hit (DMW0 misses on segment).
    csr_dmw1 = 32'h8A00_0029;
    present(32'h8000_0100, 2'd1);
    tick();
    req_valid = 1'b0;
    check("dmw1_paddr", resp_paddr, 32'hA000_0100);
    check("dmw1_mat", 32'(resp_mat), 2);
    complete();

    // Same DMW0 address at PLV3: bit3 clear, falls to TLB; miss on fetch.
    csr_plv = 2'd3;
    present(32'hA000_1234, 2'd0);
    check("plv3_vppn", 32'(tlb_vppn), 32'h0005_0000);
    check("plv3_odd", 32'(tlb_odd_page), 1);
    check("plv3_asid", 32'(tlb_asid), 32'h155);
    run_tlb("plv3_miss", 32'hA000_1234, 2'd0, 32'h0, 1'b1, 6'h3f);

    // TLB hit, 4 KB page, then back-pressure.
    set_tlb(1'b1, 6'd12, 20'h12345, 1'b1, 1'b1, 2'd2, 2'd3);
    present(32'h0040_3ABC, 2'd1);
    tick();
    req_valid = 1'b0;
    tick();
    set_tlb(1'b0, 6'd21, 20'hFFFFF, 1'b0, 1'b0, 2'd3, 2'd0);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_paddr", resp_paddr, 32'h1234_5ABC);
      check("hold_mat", 32'(resp_mat), 2);
      check("hold_ex", 32'(resp_ex), 0);
      tick();
    end
    complete();

    // TLB exception priorities.
    set_tlb(1'b0, 6'd12, 20'h12345, 1'b1, 1'b1, 2'd1, 2'd3);
    run_tlb("st_miss", 32'h0040_3ABC, 2'd2, 32'h0, 1'b1, 6'h3f);
    set_tlb(1'b1, 6'd12, 20'h12345, 1'b0, 1'b1, 2'd1, 2'd3);
    run_tlb("st_inv", 32'h0040_3ABC, 2'd2, 32'h0, 1'b1, 6'h02);
    run_tlb("rsv_inv", 32'h0040_3ABC, 2'd3, 32'h0, 1'b1, 6'h01);
    set_tlb(1'b1, 6'd12, 20'h12345, 1'b1, 1'b1, 2'd1, 2'd0);
    run_tlb("ppi", 32'h0040_3ABC, 2'd1, 32'h0, 1'b1, 6'h07);
    csr_plv = 2'd0;
    set_tlb(1'b1, 6'd12, 20'h12345, 1'b1, 1'b0, 2'd1, 2'd0);
    run_tlb("pme", 32'h0040_3ABC, 2'd2, 32'h0, 1'b1, 6'h04);
    check("pme_mat", 32'(resp_mat), 0);

    // 2 MB page: {ppn[19:9], vaddr[20:0]} = {11'h005, 21'h123456}.
    set_tlb(1'b1, 6'd21, 20'h00A00, 1'b1, 1'b1, 2'd1, 2'd0);
    run_tlb("ps21", 32'h0012_3456, 2'd1, 32'h00B2_3456, 1'b0, 6'h00);

    // Flush during LOOKUP.
    present(32'h0012_3456, 2'd1);
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_lookup_novalid", 32'(resp_valid), 0);
    check("flush_lookup_idle", 32'(req_ready), 1);
    tick();
    check("flush_lookup_still_idle", 32'(resp_valid), 0);

    // Request together with flush is not accepted.
    flush = 1'b1;
    present(32'h0012_3456, 2'd1);
    check("flush_req_ready", 32'(req_ready), 0);
    check("flush_req_fetch", 32'(tlb_fetch), 0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_req_noaccept", 32'(req_ready), 1);
    tick();
    check("flush_req_novalid", 32'(resp_valid), 0);

    // Flush coinciding with resp_ready in RESP: one completion only.
    csr_da = 1'b1;
    present(32'h0000_0040, 2'd1);
    tick();
    req_valid = 1'b0;
    check("flush_resp_valid", 32'(resp_valid), 1);
    flush = 1'b1;
    resp_ready = 1'b1;
    tick();
    flush = 1'b0;
    resp_ready = 1'b0;
    #1;
    check("flush_resp_done", 32'(resp_valid), 0);
    tick();
    check("flush_resp_no_second", 32'(resp_valid), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
